// File: rtl/filter_stim_gen_pkg.sv
// rtl/filter_stim_gen_pkg.sv - shared encodings and defaults for the filter stimulus generator
package filter_stim_gen_pkg;

    localparam int REG_MAX_DEF = 32;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        MODE_ZERO    = 2'd0,
        MODE_STEP    = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_IMPULSE = 2'd3
    } stim_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stim_state_t;

    // Level of the first sample of a sequence; the ramp always starts from zero.
    function automatic logic first_is_amplitude(input stim_mode_t m);
        return (m == MODE_STEP) || (m == MODE_IMPULSE);
    endfunction

endpackage

// File: rtl/filter_stim_gen.sv
// rtl/filter_stim_gen.sv - zero/step/ramp/impulse sample source feeding filter_basic
module filter_stim_gen
    import filter_stim_gen_pkg::*;
#(
    parameter int REG_MAX = REG_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [REG_MAX-1:0] amplitude,
    input  logic [REG_MAX-1:0] ramp_inc,
    input  logic [CNT_W-1:0]   num_samples,
    output logic [REG_MAX-1:0] stim_out,
    output logic               stim_valid,
    output logic [CNT_W-1:0]   sample_idx,
    output logic               busy,
    output logic               done
);

    stim_state_t        state;
    stim_mode_t         mode_q;
    logic [REG_MAX-1:0] amp_q;
    logic [REG_MAX-1:0] inc_q;
    logic [CNT_W-1:0]   n_q;
    logic [REG_MAX-1:0] acc;

    logic [REG_MAX-1:0] acc_next;
    logic               last_sample;
    stim_mode_t         mode_in;

    assign mode_in     = stim_mode_t'(mode);
    assign acc_next    = acc + inc_q;
    assign last_sample = (sample_idx == (n_q - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_ZERO;
            amp_q      <= '0;
            inc_q      <= '0;
            n_q        <= '0;
            acc        <= '0;
            stim_out   <= '0;
            stim_valid <= 1'b0;
            sample_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        mode_q     <= mode_in;
                        amp_q      <= amplitude;
                        inc_q      <= ramp_inc;
                        n_q        <= num_samples;
                        acc        <= '0;
                        sample_idx <= '0;
                        if (num_samples != '0) begin
                            state      <= ST_RUN;
                            stim_valid <= 1'b1;
                            busy       <= 1'b1;
                            stim_out   <= first_is_amplitude(mode_in) ? amplitude : '0;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort || last_sample) begin
                        // Abort takes priority over completion so an aborted run never pulses done.
                        state      <= abort ? ST_IDLE : ST_DONE;
                        done       <= !abort;
                        stim_out   <= '0;
                        stim_valid <= 1'b0;
                        busy       <= 1'b0;
                        sample_idx <= '0;
                    end else begin
                        sample_idx <= sample_idx + CNT_W'(1);
                        acc        <= acc_next;
                        case (mode_q)
                            MODE_STEP: stim_out <= amp_q;
                            MODE_RAMP: stim_out <= acc_next;
                            default:   stim_out <= '0;
                        endcase
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state      <= ST_IDLE;
                    stim_out   <= '0;
                    stim_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
